// File: rtl/row_predecoder_pkg.sv
// Shared definitions for the pulsed row predecoder.
//   state_t            : operation FSM states (IDLE, ASSERT, RECOVER)
//   CNT_W              : width of the pulse/gap down-counter
//   DEFAULT_ACTIVE_LOW : default output polarity (1 = asserted line driven 0)
//   MAX_* / MIN_*      : legal parameter limits, checked at elaboration
package row_predecoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_RECOVER = 2'd2
   } state_t;

   localparam int CNT_W              = 4;
   localparam bit DEFAULT_ACTIVE_LOW = 1'b1;

   localparam int MIN_ADDR_W    = 1;
   localparam int MAX_ADDR_W    = 8;
   localparam int MIN_PULSE_CYC = 1;
   localparam int MAX_CYC       = (1 << CNT_W) - 1;

endpackage

// File: rtl/onehot_decoder.sv
// Combinational address decoder.
//   addr   : line index
//   all    : broadcast, overrides addr and selects every line
//   onehot : active-high select bus, 2**ADDR_W wide
module onehot_decoder #(
   parameter int ADDR_W = 4
) (
   input  logic [ADDR_W-1:0]      addr,
   input  logic                   all,
   output logic [(1<<ADDR_W)-1:0] onehot
);

   // NOTE: the default assignment first means every path writes onehot,
   // so no latch is inferred.
   always_comb begin
      onehot = '0;
      if (all) begin
         onehot = '1;
      end else begin
         onehot[addr] = 1'b1;
      end
   end

endmodule

// File: rtl/row_predecoder_pulsed.sv
// Pulsed row predecoder: accepts one request at a time, asserts the selected
// line (or every line) for PULSE_CYC cycles from a register, then holds all
// lines inactive for GAP_CYC recovery cycles before accepting again.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   req_valid  : request present          req_ready : state is IDLE
//   req_addr   : line index               req_all   : select every line
//   dec_out    : registered line-select bus, polarity set by ACTIVE_LOW
//   busy       : ASSERT or RECOVER        done      : last cycle of an op
module row_predecoder_pulsed
   import row_predecoder_pkg::*;
#(
   parameter int ADDR_W     = 4,
   parameter int PULSE_CYC  = 2,
   parameter int GAP_CYC    = 1,
   parameter bit ACTIVE_LOW = DEFAULT_ACTIVE_LOW
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic                   req_all,
   output logic [(1<<ADDR_W)-1:0] dec_out,
   output logic                   busy,
   output logic                   done
);

   localparam int LINES = 1 << ADDR_W;
   localparam logic [LINES-1:0] INACTIVE = ACTIVE_LOW ? {LINES{1'b1}} : {LINES{1'b0}};
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

   if (ADDR_W < MIN_ADDR_W || ADDR_W > MAX_ADDR_W) begin : g_bad_addr_w
      $error("row_predecoder_pulsed: ADDR_W=%0d out of range 1..8", ADDR_W);
   end
   if (PULSE_CYC < MIN_PULSE_CYC || PULSE_CYC > MAX_CYC) begin : g_bad_pulse
      $error("row_predecoder_pulsed: PULSE_CYC=%0d out of range 1..15", PULSE_CYC);
   end
   if (GAP_CYC < 0 || GAP_CYC > MAX_CYC) begin : g_bad_gap
      $error("row_predecoder_pulsed: GAP_CYC=%0d out of range 0..15", GAP_CYC);
   end

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [ADDR_W-1:0] cap_addr;
   logic              cap_all;
   logic [LINES-1:0]  dec_q, dec_nx, onehot;
   logic [ADDR_W-1:0] dec_addr;
   logic              dec_all;
   logic              handshake;

   assign req_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign handshake = req_valid & req_ready;

   // On the handshake edge the live request is decoded so the line asserts in
   // the very next cycle; afterwards the captured copy keeps it steady.
   assign dec_addr = handshake ? req_addr : cap_addr;
   assign dec_all  = handshake ? req_all  : cap_all;

   onehot_decoder #(.ADDR_W(ADDR_W)) u_dec (
      .addr   (dec_addr),
      .all    (dec_all),
      .onehot (onehot)
   );

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      dec_nx   = INACTIVE;
      done     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (handshake) begin
               state_nx = ST_ASSERT;
               cnt_nx   = PULSE_LOAD;
               dec_nx   = ACTIVE_LOW ? ~onehot : onehot;
            end
         end
         ST_ASSERT: begin
            if (cnt == '0) begin
               // Lines drop at this edge; done marks the op end only when
               // there is no recovery phase to follow.
               if (GAP_CYC > 0) begin
                  state_nx = ST_RECOVER;
                  cnt_nx   = GAP_LOAD;
               end else begin
                  state_nx = ST_IDLE;
                  done     = 1'b1;
               end
            end else begin
               cnt_nx = cnt - 1'b1;
               dec_nx = ACTIVE_LOW ? ~onehot : onehot;
            end
         end
         ST_RECOVER: begin
            if (cnt == '0) begin
               state_nx = ST_IDLE;
               done     = 1'b1;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values; the async reset clears dec_q at once, which
   // drops an asserted line without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         cap_addr <= '0;
         cap_all  <= 1'b0;
         dec_q    <= INACTIVE;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         dec_q <= dec_nx;
         if (handshake) begin
            cap_addr <= req_addr;
            cap_all  <= req_all;
         end
      end
   end

   assign dec_out = dec_q;

endmodule

// File: tb/tb_row_predecoder_pulsed.sv
// Self-checking bench for row_predecoder_pulsed.
//   dut_a : defaults (ADDR_W=4, PULSE_CYC=2, GAP_CYC=1, active-low)
//   dut_b : ADDR_W=3, PULSE_CYC=1, GAP_CYC=0, active-high
module tb_row_predecoder_pulsed;

   logic clk = 1'b0;
   logic rst_n;

   logic        valid_a, ready_a, all_a, busy_a, done_a;
   logic [3:0]  addr_a;
   logic [15:0] dec_a;

   logic        valid_b, ready_b, all_b, busy_b, done_b;
   logic [2:0]  addr_b;
   logic [7:0]  dec_b;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   row_predecoder_pulsed dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (valid_a),
      .req_ready (ready_a),
      .req_addr  (addr_a),
      .req_all   (all_a),
      .dec_out   (dec_a),
      .busy      (busy_a),
      .done      (done_a)
   );

   row_predecoder_pulsed #(
      .ADDR_W(3), .PULSE_CYC(1), .GAP_CYC(0), .ACTIVE_LOW(1'b0)
   ) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (valid_b),
      .req_ready (ready_b),
      .req_addr  (addr_b),
      .req_all   (all_b),
      .dec_out   (dec_b),
      .busy      (busy_b),
      .done      (done_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [3:0]  addr;
      logic        all;
      logic [15:0] exp_dec;
   } vec_t;

   // One full default-config operation, entered just after an edge in IDLE.
   task automatic op_a(input int id, input logic [3:0] addr, input logic all,
                       input logic [15:0] exp);
      valid_a = 1'b1;
      addr_a  = addr;
      all_a   = all;
      tick();
      valid_a = 1'b0;
      addr_a  = ~addr;
      all_a   = ~all;
      check($sformatf("v%0d_dec_c1", id), 32'(dec_a), 32'(exp));
      check($sformatf("v%0d_busy_c1", id), 32'(busy_a), 32'd1);
      check($sformatf("v%0d_ready_c1", id), 32'(ready_a), 32'd0);
      tick();
      check($sformatf("v%0d_dec_c2", id), 32'(dec_a), 32'(exp));
      check($sformatf("v%0d_done_c2", id), 32'(done_a), 32'd0);
      tick();
      check($sformatf("v%0d_dec_gap", id), 32'(dec_a), 32'hFFFF);
      check($sformatf("v%0d_done_gap", id), 32'(done_a), 32'd1);
      tick();
      check($sformatf("v%0d_ready_idle", id), 32'(ready_a), 32'd1);
      check($sformatf("v%0d_done_idle", id), 32'(done_a), 32'd0);
      check($sformatf("v%0d_dec_idle", id), 32'(dec_a), 32'hFFFF);
      all_a = 1'b0;
   endtask

   initial begin
      vec_t vecs[5];
      int   asserted, dones;
      logic [15:0] exp16;
      logic [7:0]  exp8;

      vecs[0] = '{addr: 4'd5,  all: 1'b0, exp_dec: 16'hFFDF};
      vecs[1] = '{addr: 4'd9,  all: 1'b1, exp_dec: 16'h0000};
      vecs[2] = '{addr: 4'd0,  all: 1'b0, exp_dec: 16'hFFFE};
      vecs[3] = '{addr: 4'd15, all: 1'b0, exp_dec: 16'h7FFF};
      vecs[4] = '{addr: 4'd8,  all: 1'b0, exp_dec: 16'hFEFF};

      rst_n   = 1'b0;
      valid_a = 1'b0; addr_a = '0; all_a = 1'b0;
      valid_b = 1'b0; addr_b = '0; all_b = 1'b0;

      // Reset state, held across edges.
      tick();
      tick();
      check("rst_dec_a",  32'(dec_a),  32'hFFFF);
      check("rst_busy_a", 32'(busy_a), 32'd0);
      check("rst_done_a", 32'(done_a), 32'd0);
      check("rst_dec_b",  32'(dec_b),  32'h00);
      rst_n = 1'b1;
      tick();
      check("rst_ready_a", 32'(ready_a), 32'd1);
      check("rst_ready_b", 32'(ready_b), 32'd1);

      // Table-driven single operations.
      for (int i = 0; i < 5; i++) begin
         op_a(i, vecs[i].addr, vecs[i].all, vecs[i].exp_dec);
      end

      // Back-to-back with valid held: 3 then 12, second asserts 4 cycles later.
      valid_a = 1'b1;
      addr_a  = 4'd3;
      tick();
      check("b2b_first", 32'(dec_a), 32'hFFF7);
      addr_a = 4'd12;
      tick();
      check("b2b_first_hold", 32'(dec_a), 32'hFFF7);
      tick();
      check("b2b_gap", 32'(dec_a), 32'hFFFF);
      tick();
      check("b2b_idle_dec", 32'(dec_a), 32'hFFFF);
      check("b2b_idle_ready", 32'(ready_a), 32'd1);
      tick();
      valid_a = 1'b0;
      check("b2b_second", 32'(dec_a), 32'hEFFF);
      tick();
      tick();
      tick();
      check("b2b_end_ready", 32'(ready_a), 32'd1);

      // Reset mid-ASSERT on line 7.
      valid_a = 1'b1;
      addr_a  = 4'd7;
      tick();
      valid_a = 1'b0;
      check("rmid_assert", 32'(dec_a), 32'hFF7F);
      #2;
      rst_n = 1'b0;
      #1;
      check("rmid_dec",  32'(dec_a),  32'hFFFF);
      check("rmid_busy", 32'(busy_a), 32'd0);
      check("rmid_done", 32'(done_a), 32'd0);
      tick();
      rst_n = 1'b1;
      dones = 0;
      for (int c = 0; c < 4; c++) begin
         if (done_a) dones++;
         tick();
      end
      check("rmid_no_done", 32'(dones), 32'd0);
      check("rmid_ready",   32'(ready_a), 32'd1);

      // Small config: addr 6, single-cycle pulse, done in the same cycle.
      valid_b = 1'b1;
      addr_b  = 3'd6;
      tick();
      valid_b = 1'b0;
      check("b_dec",  32'(dec_b),  32'h40);
      check("b_done", 32'(done_b), 32'd1);
      check("b_busy", 32'(busy_b), 32'd1);
      tick();
      check("b_dec_after", 32'(dec_b),   32'h00);
      check("b_ready",     32'(ready_b), 32'd1);
      check("b_done_low",  32'(done_b),  32'd0);

      // Sweep every address on both configs; measure pulse width and shape.
      for (int i = 0; i < 16; i++) begin
         all_a  = (i % 5 == 4);
         addr_a = 4'(i);
         exp16  = all_a ? 16'h0000 : ~(16'h0001 << i);
         valid_a = 1'b1;
         tick();
         valid_a = 1'b0;
         addr_a  = 4'(i + 3);
         asserted = 0;
         dones    = 0;
         for (int c = 0; c < 6; c++) begin
            if (dec_a !== 16'hFFFF) begin
               asserted++;
               check($sformatf("sw_a%0d_shape", i), 32'(dec_a), 32'(exp16));
            end
            if (done_a) dones++;
            tick();
         end
         check($sformatf("sw_a%0d_width", i), 32'(asserted), 32'd2);
         check($sformatf("sw_a%0d_done", i),  32'(dones),    32'd1);
      end
      all_a = 1'b0;

      for (int i = 0; i < 8; i++) begin
         all_b  = (i == 5);
         addr_b = 3'(i);
         exp8   = all_b ? 8'hFF : (8'h01 << i);
         valid_b = 1'b1;
         tick();
         valid_b = 1'b0;
         addr_b  = 3'(i + 1);
         asserted = 0;
         for (int c = 0; c < 4; c++) begin
            if (dec_b !== 8'h00) begin
               asserted++;
               check($sformatf("sw_b%0d_shape", i), 32'(dec_b), 32'(exp8));
            end
            tick();
         end
         check($sformatf("sw_b%0d_width", i), 32'(asserted), 32'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
